// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with same-cycle hits and a single-block refill FSM.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module instr_cache #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 3
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    PC,
    output logic [31:0]                    INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           MEM_READ,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    input  logic [127:0]                   MEM_READDATA,
    input  logic                           MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                    HIT_COUNT,
    output logic [15:0]                    MISS_COUNT
`endif
);

    localparam int unsigned ADDR_W     = TAG_BITS + INDEX_BITS;
    localparam int unsigned NUM_BLOCKS = 1 << INDEX_BITS;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic {
        S_IDLE,
        S_MEM_READ
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]            blk_offset;
    logic [INDEX_BITS-1:0] blk_index;
    logic [TAG_BITS-1:0]   blk_tag;
    logic                  unused_pc;

    logic [NUM_BLOCKS-1:0] valid_arr;
    logic [TAG_BITS-1:0]   tag_arr  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_arr [NUM_BLOCKS];

    logic                  hit;
    logic                  miss_start;
    logic                  fill_en;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;

    // Address decomposition; bits above the cached 1 KB window and the byte offset are dropped
    assign blk_offset = PC[3:2];
    assign blk_index  = PC[INDEX_BITS+3:4];
    assign blk_tag    = PC[ADDR_W+3:INDEX_BITS+4];
    assign unused_pc  = ^{PC[31:ADDR_W+4], PC[1:0]};

    assign hit         = valid_arr[blk_index] && (tag_arr[blk_index] == blk_tag);
    assign INSTRUCTION = hit ? data_arr[blk_index][{blk_offset, 5'b0} +: WORD_W] : '0;

    // Refill always targets the latched block address, not the live PC
    assign fill_index = MEM_ADDRESS[INDEX_BITS-1:0];
    assign fill_tag   = MEM_ADDRESS[ADDR_W-1:INDEX_BITS];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        BUSYWAIT   = 1'b0;
        MEM_READ   = 1'b0;
        miss_start = 1'b0;
        fill_en    = 1'b0;
        case (state)
            S_IDLE: begin
                BUSYWAIT = !hit;
                if (!hit) begin
                    miss_start = 1'b1;
                    next_state = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill_en    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MEM_ADDRESS <= '0;
        end else if (miss_start) begin
            MEM_ADDRESS <= {blk_tag, blk_index};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_arr <= '0;
        end else if (fill_en) begin
            valid_arr[fill_index] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_arr[fill_index]  <= fill_tag;
            data_arr[fill_index] <= MEM_READDATA;
        end
    end

`ifdef ICACHE_STATS_EN
    logic refill_done;
    logic hit_inc;

    // The fetch that caused a refill was already counted as a miss
    assign hit_inc = (state == S_IDLE) && hit && !refill_done;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            refill_done <= 1'b0;
            HIT_COUNT   <= '0;
            MISS_COUNT  <= '0;
        end else begin
            refill_done <= fill_en;
            if (hit_inc && (HIT_COUNT != 16'hFFFF)) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
            if (miss_start && (MISS_COUNT != 16'hFFFF)) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule
